pc_sequencer: RTL

Program-flow controller that sits directly upstream of the MC14516B program counter in the MC14500B system. It consumes the ICU's JMP/RTN/FLG0/FLGF flag pulses and the instruction operand, keeps a small return-address stack, and drives the counter's `preset`, `preset_enable` and `carry_in` (count inhibit). Effects: jumps, subroutine calls and returns, and halt/resume of instruction fetch.

---
 rtl/mc14500b_pkg.sv | 16 +
 rtl/pc_return_stack.sv | 70 +++++++
 rtl/pc_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mc14500b_pkg.sv
// mc14500b_pkg: definitions shared by the MC14500B program-flow blocks.
//   - ADDR_W_DEFAULT / DEPTH_DEFAULT: default program address width and
//     return-stack depth.
//   - seq_state_e: program-flow controller states.
package mc14500b_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 4;
    localparam int unsigned DEPTH_DEFAULT  = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StHalt = 2'd2
    } seq_state_e;

endpackage

// File: rtl/pc_return_stack.sv
// pc_return_stack: LIFO of return addresses, DEPTH entries of ADDR_W bits.
//   clock, reset : rising-edge clock, asynchronous active-low reset (empties the stack)
//   push, wdata  : push wdata onto the top (ignored when full, unless popping too)
//   pop, rdata   : pop the top; rdata is combinational from the current top entry
//   count        : number of stored entries
//   full, empty  : occupancy status
module pc_return_stack
    import mc14500b_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DEPTH  = DEPTH_DEFAULT
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_W-1:0]            wdata,
    output logic [ADDR_W-1:0]            rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEPTH);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [CntW-1:0]   count_q, count_d;
    logic [IdxW-1:0]   top_idx, wr_idx;
    logic              do_push, do_pop, do_replace;

    assign full    = (count_q == CntMax);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign top_idx = IdxW'(count_q - CntW'(1));

    // Simultaneous push and pop overwrites the top entry in place.
    assign do_push    = push && !pop && !full;
    assign do_pop     = pop && !push && !empty;
    assign do_replace = push && pop && !empty;
    assign wr_idx     = do_replace ? top_idx : IdxW'(count_q);

    assign rdata = empty ? '0 : mem_q[top_idx];

    always_comb begin
        count_d = count_q;
        if (do_push) begin
            count_d = count_q + CntW'(1);
        end else if (do_pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries above count are never read.
    always_ff @(posedge clock) begin
        if (do_push || do_replace) begin
            mem_q[wr_idx] <= wdata;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-flow controller driving the MC14516B program counter.
// Decodes ICU flag pulses into JUMP / CALL / RETURN / HALT and keeps a return stack.
//   clock, reset         : rising-edge clock, asynchronous active-low reset
//   jmp, rtn, flg0, flgf : ICU flags (jmp+flg0 = CALL, flgf = HALT request)
//   run                  : resume pulse, leaves HALT
//   clr_err              : clears sticky error flags (a same-cycle set wins)
//   operand              : jump/call target
//   pc                   : address of the instruction currently executing
//   preset, preset_enable: counter load value and load strobe (one cycle)
//   carry_in             : counter inhibit, high in LOAD and HALT
//   halted               : high in HALT
//   sp                   : number of stacked return addresses
//   overflow, underflow, conflict : sticky error flags
module pc_sequencer
    import mc14500b_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DEPTH  = DEPTH_DEFAULT
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         jmp,
    input  logic                         rtn,
    input  logic                         flg0,
    input  logic                         flgf,
    input  logic                         run,
    input  logic                         clr_err,
    input  logic [ADDR_W-1:0]            operand,
    input  logic [ADDR_W-1:0]            pc,
    output logic [ADDR_W-1:0]            preset,
    output logic                         preset_enable,
    output logic                         carry_in,
    output logic                         halted,
    output logic [$clog2(DEPTH+1)-1:0]   sp,
    output logic                         overflow,
    output logic                         underflow,
    output logic                         conflict
);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] ret_addr;
    logic              stk_push, stk_pop;
    logic [ADDR_W-1:0] stk_rdata;
    logic              stk_full, stk_empty;
    logic              ovf_set, unf_set, conf_set;

    logic [ADDR_W-1:0] preset_q, preset_d;
    logic              pe_q, pe_d;
    logic              ci_q, ci_d;
    logic              halted_q, halted_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              conf_q, conf_d;

    // Return to the instruction after the call; wraps at the top of memory.
    assign ret_addr = pc + ADDR_W'(1);

    pc_return_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_stack (
        .clock (clock),
        .reset (reset),
        .push  (stk_push),
        .pop   (stk_pop),
        .wdata (ret_addr),
        .rdata (stk_rdata),
        .count (sp),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, stack control and error events. Flags are only decoded in IDLE.
    always_comb begin
        state_d  = state_q;
        target   = preset_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        conf_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (jmp && rtn) begin
                    conf_set = 1'b1;
                end else if (jmp && !flg0) begin
                    target  = operand;
                    state_d = StLoad;
                end else if (jmp) begin
                    if (stk_full) begin
                        ovf_set = 1'b1;
                    end else begin
                        stk_push = 1'b1;
                        target   = operand;
                        state_d  = StLoad;
                    end
                end else if (rtn) begin
                    if (stk_empty) begin
                        unf_set = 1'b1;
                    end else begin
                        stk_pop = 1'b1;
                        target  = stk_rdata;
                        state_d = StLoad;
                    end
                end else if (flgf) begin
                    state_d = StHalt;
                end
            end
            StLoad: begin
                state_d = StIdle;
            end
            StHalt: begin
                if (run) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output next values, derived from the upcoming state so outputs come straight from flops.
    always_comb begin
        preset_d = (state_d == StLoad) ? target : preset_q;
        pe_d     = (state_d == StLoad);
        ci_d     = (state_d != StIdle);
        halted_d = (state_d == StHalt);
        ovf_d    = ovf_set  | (ovf_q  & ~clr_err);
        unf_d    = unf_set  | (unf_q  & ~clr_err);
        conf_d   = conf_set | (conf_q & ~clr_err);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            preset_q <= '0;
            pe_q     <= 1'b0;
            ci_q     <= 1'b0;
            halted_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            conf_q   <= 1'b0;
        end else begin
            preset_q <= preset_d;
            pe_q     <= pe_d;
            ci_q     <= ci_d;
            halted_q <= halted_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            conf_q   <= conf_d;
        end
    end

    assign preset        = preset_q;
    assign preset_enable = pe_q;
    assign carry_in      = ci_q;
    assign halted        = halted_q;
    assign overflow      = ovf_q;
    assign underflow     = unf_q;
    assign conflict      = conf_q;

endmodule
